// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide execution unit. Sits beside the integer ALU
// in the execute stage and is selected when funct7 == 0x01. One bit of the
// product or quotient is produced per cycle: shift-add for multiply,
// restoring division for divide/remainder. Signed operands are reduced to
// magnitudes when the request is accepted; the sign is restored on the
// CALC->DONE transition.
//
// DATA_WIDTH must be even and at least 4.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   flush      in   synchronous abort of any in-flight operation
//   in_valid   in   request valid
//   in_ready   out  unit idle and able to accept a request
//   lhs        in   rs1 operand          [DATA_WIDTH]
//   rhs        in   rs2 operand          [DATA_WIDTH]
//   operation  in   funct3               [3]
//   metadata   in   funct7               [7]
//   out_valid  out  result valid
//   out_ready  in   consumer takes the result
//   result     out  operation result     [DATA_WIDTH]
//   illegal    out  qualifies out_valid: request was not an M-extension op
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic [2:0]            operation,
  input  logic [6:0]            metadata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W + 1);

  localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Two's-complement negation helpers used for sign conversion and correction.
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    return ~v + W'(1);
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    return ~v + (2*W)'(1);
  endfunction

  // Iteration registers. Multiply: acc_hi = running high half, acc_lo =
  // multiplier shifting out / product low half shifting in, opnd = multiplicand.
  // Divide: acc_hi = partial remainder, acc_lo = dividend shifting out /
  // quotient shifting in, opnd = divisor.
  logic [CNT_W-1:0] count;
  logic [W-1:0]     acc_hi;
  logic [W-1:0]     acc_lo;
  logic [W-1:0]     opnd;
  logic [2:0]       op_q;
  logic             neg_main;   // negate product / quotient
  logic             neg_rem;    // negate remainder (dividend was negative)

  // Request decode
  logic          accept;
  logic          is_m;
  logic          is_div;
  logic          lhs_signed;
  logic          rhs_signed;
  logic          lhs_neg;
  logic          rhs_neg;
  logic          div_zero;
  logic          div_ovf;
  logic          special;
  logic [W-1:0]  lhs_mag;
  logic [W-1:0]  rhs_mag;
  logic [W-1:0]  special_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign accept     = in_valid && in_ready && !flush;
  assign is_m       = (metadata == 7'h01);
  assign is_div     = operation[2];
  // MUL (funct3 0) only yields the low half, which is sign-agnostic, so it is
  // run unsigned.
  assign lhs_signed = (operation == 3'd1) || (operation == 3'd2) ||
                      (operation == 3'd4) || (operation == 3'd6);
  assign rhs_signed = (operation == 3'd1) || (operation == 3'd4) ||
                      (operation == 3'd6);
  assign lhs_neg    = lhs_signed && lhs[W-1];
  assign rhs_neg    = rhs_signed && rhs[W-1];
  // The most negative value maps onto itself, which is also its correct
  // unsigned magnitude.
  assign lhs_mag    = lhs_neg ? neg_w(lhs) : lhs;
  assign rhs_mag    = rhs_neg ? neg_w(rhs) : rhs;
  assign div_zero   = is_div && (rhs == '0);
  assign div_ovf    = is_div && !operation[0] && (lhs == MOST_NEG) && (rhs == '1);
  assign special    = !is_m || div_zero || div_ovf;

  // Results that bypass the iterative core. operation[1] separates the
  // remainder ops (6, 7) from the quotient ops (4, 5).
  always_comb begin
    special_res = '0;
    if (!is_m) begin
      special_res = '0;
    end else if (div_zero) begin
      special_res = operation[1] ? lhs : '1;
    end else if (div_ovf) begin
      special_res = operation[1] ? '0 : lhs;
    end
  end

  // One iteration of the unsigned core
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic [W:0]   div_diff;
  logic [W-1:0] hi_nxt;
  logic [W-1:0] lo_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[W-1]};
    // The partial remainder is always below the divisor, so the shifted value
    // is below twice the divisor and the top bit of the difference is a
    // reliable borrow flag.
    div_diff  = div_shift - {1'b0, opnd};
    if (op_q[2]) begin
      if (!div_diff[W]) begin
        hi_nxt = div_diff[W-1:0];
        lo_nxt = {acc_lo[W-2:0], 1'b1};
      end else begin
        hi_nxt = div_shift[W-1:0];
        lo_nxt = {acc_lo[W-2:0], 1'b0};
      end
    end else begin
      hi_nxt = mul_sum[W:1];
      lo_nxt = {mul_sum[0], acc_lo[W-1:1]};
    end
  end

  // Sign correction and result selection on the final iteration
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   final_res;

  always_comb begin
    prod_fix  = neg_main ? neg_2w({hi_nxt, lo_nxt}) : {hi_nxt, lo_nxt};
    final_res = '0;
    case (op_q)
      3'd0:                final_res = prod_fix[W-1:0];
      3'd1, 3'd2, 3'd3:    final_res = prod_fix[2*W-1:W];
      3'd4, 3'd5:          final_res = neg_main ? neg_w(lo_nxt) : lo_nxt;
      default:             final_res = neg_rem ? neg_w(hi_nxt) : hi_nxt;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (count == CNT_ONE) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Accept / iterate / retire datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      op_q     <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      result   <= '0;
      illegal  <= 1'b0;
    end else if (accept) begin
      op_q     <= operation;
      neg_main <= lhs_neg ^ rhs_neg;
      neg_rem  <= lhs_neg;
      count    <= CNT_INIT;
      acc_hi   <= '0;
      acc_lo   <= is_div ? lhs_mag : rhs_mag;
      opnd     <= is_div ? rhs_mag : lhs_mag;
      if (special) begin
        result  <= special_res;
        illegal <= !is_m;
      end
    end else if (state == CALC && !flush) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      count  <= count - CNT_ONE;
      if (count == CNT_ONE) begin
        result  <= final_res;
        illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Scoreboard bench for muldiv_unit (DATA_WIDTH = 32). A driver issues requests
// and pushes the reference-model response (result, illegal, latency, requested
// backpressure) into a queue; an independent monitor acts as the consumer,
// pops an entry whenever out_valid rises, compares it, and holds out_ready low
// for the requested number of cycles while checking the output stays stable.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [2:0]  operation;
  logic [6:0]  metadata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lhs       (lhs),
    .rhs       (rhs),
    .operation (operation),
    .metadata  (metadata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          hold;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   active   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [6:0] meta,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t              e;
    int                si, sj;
    longint            sa, sb64, ps;
    longint unsigned   ua, ub, pu;
    e.res = '0; e.ill = 1'b0; e.lat = 33; e.hold = 0; e.acc = 0;
    si = $signed(a); sj = $signed(b);
    sa = si; sb64 = sj;
    ua = {32'd0, a}; ub = {32'd0, b};
    if (meta != 7'h01) begin
      e.ill = 1'b1; e.res = '0; e.lat = 1;
      return e;
    end
    case (op)
      3'd0: begin pu = ua * ub;           e.res = pu[31:0];  end
      3'd1: begin ps = sa * sb64;         e.res = ps[63:32]; end
      3'd2: begin ps = sa * longint'(ub); e.res = ps[63:32]; end
      3'd3: begin pu = ua * ub;           e.res = pu[63:32]; end
      3'd4, 3'd6: begin
        if (b == 0) begin
          e.lat = 1; e.res = (op == 3'd4) ? 32'hFFFF_FFFF : a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lat = 1; e.res = (op == 3'd4) ? a : 32'd0;
        end else begin
          e.res = (op == 3'd4) ? (si / sj) : (si % sj);
        end
      end
      default: begin
        if (b == 0) begin
          e.lat = 1; e.res = (op == 3'd5) ? 32'hFFFF_FFFF : a;
        end else begin
          e.res = (op == 3'd5) ? (a / b) : (a % b);
        end
      end
    endcase
    return e;
  endfunction

  // Driver: one request, expected response pushed after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [6:0] meta,
                       input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("issue_wait_ready", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1; operation = op; metadata = meta; lhs = a; rhs = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lhs = $urandom; rhs = $urandom;
    operation = 3'($urandom); metadata = 7'($urandom);
    e = model(op, meta, a, b);
    e.hold = hold;
    e.acc  = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(in_ready && sb.size() == 0 && !active) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Monitor / consumer
  initial begin : monitor
    exp_t cur;
    int   hold;
    out_ready = 1'b0;
    hold = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active    = 1'b0;
        out_ready = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (!active) begin
          active = 1'b1;
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            cur.hold = 0; cur.res = result; cur.ill = illegal;
          end else begin
            cur = sb.pop_front();
            chk("result",   result, cur.res);
            chk("illegal",  {31'd0, illegal}, {31'd0, cur.ill});
            chk("latency",  32'(cyc - cur.acc + 1), 32'(cur.lat));
            chk("done_in_ready", {31'd0, in_ready}, 32'd0);
          end
          hold = cur.hold;
        end else begin
          chk("held_result",   result, cur.res);
          chk("held_illegal",  {31'd0, illegal}, {31'd0, cur.ill});
          chk("held_in_ready", {31'd0, in_ready}, 32'd0);
        end
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        if (active && out_ready) begin
          chk("consumed_in_ready", {31'd0, in_ready}, 32'd1);
        end
        active    = 1'b0;
        out_ready = 1'b0;
      end
    end
  end

  // Abort a MUL at iteration 10 with flush or reset, then run DIVU 9/3.
  task automatic abort_test(input bit use_rst);
    bit seen;
    wait_idle();
    @(negedge clk);
    in_valid = 1'b1; operation = 3'd0; metadata = 7'h01; lhs = $urandom; rhs = $urandom;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    if (use_rst) begin
      rst = 1'b0;
      #1;
      chk("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_result",    result,             32'd0);
      chk("rst_mid_illegal",   {31'd0, illegal},   32'd0);
      @(negedge clk);
      #2 rst = 1'b1;
    end else begin
      flush = 1'b1;
      @(posedge clk);
      #1;
      chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      // Flush colliding with a request in IDLE: request must be dropped.
      in_valid = 1'b1; operation = 3'd5; metadata = 7'h01; lhs = 32'd8; rhs = 32'd2;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_collide_in_ready", {31'd0, in_ready}, 32'd1);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_out_valid", {31'd0, seen},     32'd0);
    chk("abort_in_ready",     {31'd0, in_ready}, 32'd1);
    issue(3'd5, 7'h01, 32'd9, 32'd3, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : driver
    logic [6:0] m;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    lhs = '0; rhs = '0; operation = '0; metadata = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result",    result,             32'd0);
    chk("reset_illegal",   {31'd0, illegal},   32'd0);
    #2 rst = 1'b1;

    issue(3'd0, 7'h01, 32'd7,          32'hFFFF_FFFD, 0);
    issue(3'd1, 7'h01, 32'h8000_0000, 32'h8000_0000, 1);
    issue(3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(3'd2, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    issue(3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2,         0);
    issue(3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2,         0);
    issue(3'd5, 7'h01, 32'd100,       32'd7,         0);
    issue(3'd7, 7'h01, 32'd100,       32'd7,         3);
    issue(3'd5, 7'h01, 32'd5,         32'd0,         0);
    issue(3'd7, 7'h01, 32'd5,         32'd0,         0);
    issue(3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(3'd0, 7'h00, 32'd12,        32'd34,        5);
    issue(3'd5, 7'h01, 32'd9,         32'd3,         0);

    abort_test(1'b0);
    abort_test(1'b1);

    for (int i = 0; i < 120; i++) begin
      m = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h01;
      issue(3'($urandom), m, pick(), pick(), $urandom_range(0, 3));
    end

    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide execution unit; successor to the single-cycle combinational integer ALU.
- Parametrised datapath width, with valid/ready handshakes on input and output, and a synchronous flush.
- Sits beside the ALU in the execute stage. Takes the same operand/funct encoding and is selected when funct7 = 0x01.
- Iterative: one bit per cycle, shift-add multiply and restoring divide.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits; must be even and >= 4.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; discards any in-flight operation.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- lhs  input  DATA_WIDTH  rs1 value.
- rhs  input  DATA_WIDTH  rs2 value.
- operation  input  3  funct3 (instr[14:12]).
- metadata  input  7  funct7 (instr[31:25]).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  DATA_WIDTH  operation result.
- illegal  output  1  qualifies out_valid; request was not an M-extension op.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; in_ready = 1; out_valid = 0; result = 0; illegal = 0.
  - Internal counter, accumulators and operand registers cleared.
- States: IDLE, CALC, DONE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
  - No back-to-back overlap: a new request is accepted only after the previous result has been consumed.
- IDLE, on in_valid && in_ready (accepting edge):
  - Latch operands, funct3 and the decode flags.
  - metadata != 0x01: set illegal = 1 and result = 0, go to DONE.
  - Divide with rhs == 0: go to DONE with
    - DIV/DIVU quotient = all ones;
    - REM/REMU remainder = lhs.
  - DIV/REM signed overflow (lhs = most negative, rhs = all ones): go to DONE with
    - DIV = lhs;
    - REM = 0.
  - Otherwise go to CALC with counter = DATA_WIDTH.
- Special cases and illegal requests: out_valid is high after exactly 1 edge.
- Normal operations: out_valid is high after exactly DATA_WIDTH + 1 edges (1 setup + DATA_WIDTH iterations).
- funct3 mapping (metadata 0x01):
  - 0 MUL: low half of product.
  - 1 MULH: high half, signed x signed.
  - 2 MULHSU: high half, signed lhs x unsigned rhs.
  - 3 MULHU: high half, unsigned x unsigned.
  - 4 DIV, 5 DIVU: quotient, truncated toward zero.
  - 6 REM, 7 REMU: remainder; sign of a signed remainder follows lhs.
- Arithmetic:
  - Signed operands are converted to magnitudes at accept; the core iterates unsigned.
  - Product accumulator is 2*DATA_WIDTH bits.
  - Final sign correction (two's-complement negate) is applied on the CALC->DONE transition:
    - product negated when the operand signs differ;
    - quotient negated when the signs differ;
    - remainder negated when lhs is negative.
- CALC: one iteration per cycle, counter decrements; at counter == 1 the result is registered and state goes to DONE.
- DONE:
  - result and illegal are held stable while out_ready is low (arbitrary backpressure).
  - On out_ready, go to IDLE; out_valid drops on the same edge.
- flush: on any edge with flush = 1, state = IDLE and out_valid = 0. Overrides an in_valid or out_ready on that same edge; the request is not accepted.
- rst low mid-operation: immediate return to the reset values; no result is ever produced for the aborted op.
- Inputs lhs/rhs/operation/metadata are ignored outside the accepting edge.

Test Plan:
- MUL lhs = 7, rhs = 0xFFFFFFFD -> result 0xFFFFFFEB, illegal 0; out_valid 33 cycles after accept.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- Special cases, each with out_valid 1 cycle after accept:
  - DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- metadata = 0x00, funct3 = 0 -> illegal 1, result 0, 1-cycle latency. Then:
  - hold out_ready low for 5 cycles -> out_valid, result and illegal stable, in_ready 0;
  - raise out_ready -> IDLE on the next edge.
- Start a MUL, then either assert flush at iteration 10, or pull rst low at iteration 10:
  - out_valid never rises and in_ready returns to 1;
  - a following DIVU 9 / 3 returns 3 with normal latency.
